moore_run_detector: RTL

- Parametrised Moore serial-stream detector that asserts its output while the last RUN_LEN accepted bits are all equal.
- Replaces the fixed 5-state "two equal consecutive bits" detector.
- Adds a configurable run length, a polarity mode, a valid qualifier, a saturating run-length report and an optional detection counter.
- Sits after a serial deserialiser/line sampler in the FSM library.

---
 rtl/moore_fsm_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/moore_run_detector.sv | 90 +++++++++
 3 files changed

// File: rtl/moore_fsm_pkg.sv
// rtl/moore_fsm_pkg.sv - State encodings and polarity-mode constants for the run detector.
package moore_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ANY   = 2'd0;
  localparam logic [1:0] MODE_ONES  = 2'd1;
  localparam logic [1:0] MODE_ZEROS = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - Up counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/moore_run_detector.sv
// rtl/moore_run_detector.sv - Moore detector flagging runs of RUN_LEN equal accepted bits.
// Optional detection counter port hit_cnt is built when MOORE_RUN_HIT_CNT_EN is defined.
module moore_run_detector
  import moore_fsm_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  output logic             q,
  output logic             q_val,
  output logic [CNT_W-1:0] run_len
`ifdef MOORE_RUN_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  state_t           state;
  state_t           bit_state;
  logic             new_run;
  logic             same_bit;
  logic [CNT_W-1:0] extra;
  logic [CNT_W:0]   len_ext;
  logic             pol_ok;

  assign bit_state = in ? RUN1 : RUN0;
  assign new_run   = in_valid && (state != bit_state);
  assign same_bit  = in_valid && (state == bit_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (in_valid) begin
      state <= bit_state;
    end
  end

  // The counter holds "bits beyond the first" so a fresh run can simply clear it.
  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (new_run),
    .inc (same_bit),
    .cnt (extra)
  );

  assign len_ext = {1'b0, extra} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    run_len = '0;
    if (state != IDLE) begin
      run_len = len_ext[CNT_W] ? '1 : len_ext[CNT_W-1:0];
    end
  end

  always_comb begin
    pol_ok = 1'b1;
    case (mode)
      MODE_ONES:  pol_ok = (state == RUN1);
      MODE_ZEROS: pol_ok = (state == RUN0);
      default:    pol_ok = 1'b1;
    endcase
  end

  assign q     = (state != IDLE) && (run_len >= CNT_W'(RUN_LEN)) && pol_ok;
  assign q_val = (state == RUN1);

`ifdef MOORE_RUN_HIT_CNT_EN
  logic q_d;

  // Counts registered rising edges of q; wraps rather than saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_d     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      q_d <= q;
      if (q && !q_d) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
